// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
//   fetch_state_e : fetch FSM states (IDLE, REQ, WAIT, DROP)
//   fetch_entry_t : one buffered fetch result, the word plus the PC it came from
package fetch_pkg;

   localparam int unsigned FETCH_AW = 32;   // PC / cache address width
   localparam int unsigned FETCH_DW = 32;   // instruction word width

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // nothing outstanding, waiting for FIFO room
      REQ  = 2'd1,   // presenting a read to the cache
      WAIT = 2'd2,   // read accepted, response still wanted
      DROP = 2'd3    // read accepted, response no longer wanted
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_AW-1:0] pc;
      logic [FETCH_DW-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched words for the decode stage.
// The head entry is read straight from the storage registers, so a pushed
// entry is visible the cycle after the push edge (no fall-through).
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   flush_i           empty the FIFO; beats push and pop in the same cycle
//   push_i, data_i    write an entry (ignored when full)
//   pop_i             drop the head entry (ignored when empty)
//   data_o            head entry
//   count_o           entries held, 0..Depth
//   full_o, empty_o   occupancy flags
module fetch_fifo #(
   parameter int unsigned Depth = 4,
   parameter type         entry_t = logic [63:0],
   parameter int unsigned PtrW  = $clog2(Depth),
   parameter int unsigned CntW  = $clog2(Depth) + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            push_i,
   input  logic            pop_i,
   input  entry_t          data_i,
   output entry_t          data_o,
   output logic [CntW-1:0] count_o,
   output logic            full_o,
   output logic            empty_o
);

   entry_t          mem_q [Depth];
   logic [PtrW-1:0] wr_q, wr_d;
   logic [PtrW-1:0] rd_q, rd_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            do_push;
   logic            do_pop;

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign data_o  = mem_q[rd_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Depth is a power of two, so pointers wrap by plain overflow.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + PtrW'(1);
         if (do_pop)  rd_d = rd_q + PtrW'(1);
         cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   // Storage is cleared on reset so the head reads as zero out of reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         if (do_push && !flush_i) mem_q[wr_q] <= data_i;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage sitting in front of the instruction cache.
// Holds the PC, issues one word read at a time, and buffers returned words
// tagged with their PC for decode. A redirect flushes the buffer and marks
// any in-flight read as unwanted.
// Handshakes:
//   cache side : a read is accepted on an edge where cache_re=1 and
//                cache_busy=0; cache_done pulses once with the data.
//   decode side: the head is consumed on an edge where out_valid=1 and
//                out_ready=1; out_valid never depends on out_ready.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   redirect, redirect_pc    load a new PC (low two bits forced to zero)
//   cache_addr, cache_re     read request to the cache (registered only)
//   cache_busy, cache_done   cache acceptance stall / response strobe
//   cache_data               returned word
//   out_valid/out_pc/out_instr, out_ready   decode-side buffer head
//   dbg_state                current FSM state (fetch_state_e encoding)
// AddrWidth/DataWidth must match FETCH_AW/FETCH_DW of fetch_pkg.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned          AddrWidth = FETCH_AW,
   parameter int unsigned          DataWidth = FETCH_DW,
   parameter logic [AddrWidth-1:0] ResetPc   = '0,
   parameter int unsigned          Depth     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 redirect,
   input  logic [AddrWidth-1:0] redirect_pc,
   output logic [AddrWidth-1:0] cache_addr,
   output logic                 cache_re,
   input  logic                 cache_busy,
   input  logic                 cache_done,
   input  logic [DataWidth-1:0] cache_data,
   output logic                 out_valid,
   output logic [AddrWidth-1:0] out_pc,
   output logic [DataWidth-1:0] out_instr,
   input  logic                 out_ready,
   output logic [1:0]           dbg_state
);

   localparam int unsigned   CntW     = $clog2(Depth) + 1;
   localparam logic [CntW:0] DepthExt = (CntW+1)'(Depth);

   fetch_state_e         state_q, state_d;
   logic [AddrWidth-1:0] pc_q, pc_d;
   logic                 push;
   logic                 pop;
   logic                 flush;
   logic [CntW-1:0]      fifo_count;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CntW:0]        cnt_after_pop;
   fetch_entry_t         push_entry;
   fetch_entry_t         head_entry;

   assign pop           = out_ready && !fifo_empty;
   assign cnt_after_pop = {1'b0, fifo_count} - (CntW+1)'(pop);
   assign push_entry    = '{pc: pc_q, instr: cache_data};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      push    = 1'b0;
      flush   = 1'b0;
      unique case (state_q)
         // Room exists if not full now, or if decode frees a slot this cycle.
         IDLE: if (!fifo_full || pop) state_d = REQ;
         REQ:  if (!cache_busy) state_d = WAIT;
         WAIT: begin
            if (cache_done) begin
               push    = 1'b1;
               pc_d    = pc_q + AddrWidth'(4);
               state_d = ((cnt_after_pop + (CntW+1)'(1)) < DepthExt) ? REQ : IDLE;
            end
         end
         DROP: if (cache_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (redirect) begin
         flush = 1'b1;
         push  = 1'b0;
         pc_d  = {redirect_pc[AddrWidth-1:2], 2'b00};
         // An outstanding read must still be absorbed unless its response
         // is arriving right now; an unaccepted REQ is simply abandoned.
         if ((state_q == WAIT || state_q == DROP) && !cache_done) state_d = DROP;
         else                                                    state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= ResetPc;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign cache_re   = (state_q == REQ);
   assign cache_addr = pc_q;
   assign dbg_state  = state_q;

   fetch_fifo #(
      .Depth   (Depth),
      .entry_t (fetch_entry_t)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (push_entry),
      .data_o  (head_entry),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out_pc    = head_entry.pc;
   assign out_instr = head_entry.instr;

   // A response with nothing outstanding means the cache and this stage disagree.
   assert property (@(posedge clk) disable iff (rst)
                    cache_done |-> (state_q == WAIT || state_q == DROP));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
   localparam int          DEPTH    = 4;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] cache_addr;
   logic        cache_re;
   logic        cache_busy = 1'b0;
   logic        cache_done = 1'b0;
   logic [31:0] cache_data = '0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready = 1'b0;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   fetch_unit #(
      .AddrWidth (32),
      .DataWidth (32),
      .ResetPc   (RESET_PC),
      .Depth     (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .cache_addr  (cache_addr),
      .cache_re    (cache_re),
      .cache_busy  (cache_busy),
      .cache_done  (cache_done),
      .cache_data  (cache_data),
      .out_valid   (out_valid),
      .out_pc      (out_pc),
      .out_instr   (out_instr),
      .out_ready   (out_ready),
      .dbg_state   (dbg_state)
   );

   // ---------------- scoreboard / reference model ----------------
   logic [63:0] exp_q[$];      // {pc, instr} words decode should see, in order
   logic [31:0] acc_q[$];      // addresses the cache accepted
   int          acc_cyc[$];    // cycle number of each acceptance
   logic [31:0] m_pc;          // architectural next-fetch PC
   logic        live;          // outstanding read is still wanted
   logic        pend_valid;    // cache has a read in flight
   int          pend_wait;     // cycles before its response
   logic [31:0] pend_data;
   int          lat_min = 0;
   int          lat_max = 0;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'hC0DE_0001;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1; redirect = 1'b0; cache_done = 1'b0; cache_busy = 1'b0;
      out_ready = 1'b0; redirect_pc = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      exp_q.delete();
      pend_valid = 1'b0; pend_wait = 0; live = 1'b0; m_pc = RESET_PC;
      check("rst_cache_re",   32'(cache_re), 32'd0);
      check("rst_cache_addr", cache_addr, RESET_PC);
      check("rst_out_valid",  32'(out_valid), 32'd0);
      check("rst_out_pc",     out_pc, 32'd0);
      check("rst_out_instr",  out_instr, 32'd0);
      check("rst_state",      32'(dbg_state), 32'(IDLE));
      rst = 1'b0;
   endtask

   // One clock: drive at negedge, model at posedge, check at next negedge.
   task automatic cycle(input logic busy, input logic rdy, input logic redir,
                        input logic [31:0] rpc);
      logic        b, dn, acc, pop;
      logic [31:0] a;
      b  = busy;
      dn = pend_valid && (pend_wait == 0);
      // Keep the cache from accepting a read in the same cycle it is abandoned.
      if (redir && cache_re && !b) b = 1'b1;
      cache_done  = dn;
      cache_data  = dn ? pend_data : $urandom();
      cache_busy  = b;
      out_ready   = rdy;
      redirect    = redir;
      redirect_pc = rpc;
      acc = cache_re && !b;
      pop = (exp_q.size() != 0) && rdy;
      a   = cache_addr;
      @(posedge clk);
      if (pop) void'(exp_q.pop_front());
      if (dn) begin
         pend_valid = 1'b0;
         if (live && !redir) begin
            exp_q.push_back({m_pc, pend_data});
            m_pc = m_pc + 32'd4;
         end
         live = 1'b0;
      end else if (pend_valid) begin
         pend_wait--;
      end
      if (redir) begin
         exp_q.delete();
         m_pc = {rpc[31:2], 2'b00};
         live = 1'b0;
      end
      if (acc) begin
         pend_valid = 1'b1;
         pend_wait  = $urandom_range(lat_max, lat_min);
         pend_data  = mem_word(a);
         live       = 1'b1;
         acc_q.push_back(a);
         acc_cyc.push_back(cyc);
      end
      cyc++;
      @(negedge clk);
      cache_done = 1'b0;
      redirect   = 1'b0;
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         check("out_pc",    out_pc,    exp_q[0][63:32]);
         check("out_instr", out_instr, exp_q[0][31:0]);
      end
      if (cache_re) check("cache_addr", cache_addr, m_pc);
      check("single_outstanding", 32'(cache_re && pend_valid), 32'd0);
      if (exp_q.size() >= DEPTH) check("no_issue_when_full", 32'(cache_re), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit found;
      int n0;

      // Reset values, first request timing, PC wrap.
      do_reset();
      lat_min = 0; lat_max = 0;
      cycle(1'b0, 1'b1, 1'b0, '0);
      check("first_re_after_rst", 32'(cache_re), 32'd1);
      repeat (7) cycle(1'b0, 1'b1, 1'b0, '0);
      check("wrap_count", 32'(acc_q.size() >= 3), 32'd1);
      if (acc_q.size() >= 3) begin
         check("wrap_pc0", acc_q[0], 32'hFFFF_FFF8);
         check("wrap_pc1", acc_q[1], 32'hFFFF_FFFC);
         check("wrap_pc2", acc_q[2], 32'h0000_0000);
      end

      // Reset while a read is outstanding.
      lat_min = 3; lat_max = 3;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         if (dbg_state == 2'(WAIT)) found = 1;
         else cycle(1'b0, 1'b1, 1'b0, '0);
      end
      check("reach_wait_for_rst", 32'(found), 32'd1);
      do_reset();

      // Back-to-back fetch from 0, 1-cycle cache, decode always ready.
      lat_min = 0; lat_max = 0;
      cycle(1'b0, 1'b1, 1'b1, 32'h0);
      acc_q.delete(); acc_cyc.delete();
      repeat (12) cycle(1'b0, 1'b1, 1'b0, '0);
      check("tput_count", 32'(acc_q.size() >= 5), 32'd1);
      if (acc_q.size() >= 5) begin
         for (int i = 0; i < 4; i++) begin
            check("tput_addr", acc_q[i], 32'(4 * i));
            check("tput_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd2);
         end
      end

      // Decode stalled: exactly Depth words, then one more per freed slot.
      acc_q.delete();
      cycle(1'b0, 1'b0, 1'b1, 32'h0);
      repeat (14) cycle(1'b0, 1'b0, 1'b0, '0);
      check("fill_count", 32'(acc_q.size()), 32'd4);
      if (acc_q.size() == 4) check("fill_last", acc_q[3], 32'hC);
      check("fill_stalled_re", 32'(cache_re), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, '0);
      repeat (8) cycle(1'b0, 1'b0, 1'b0, '0);
      check("refill_count", 32'(acc_q.size()), 32'd5);
      if (acc_q.size() == 5) check("refill_addr", acc_q[4], 32'h10);
      check("refill_stalled_re", 32'(cache_re), 32'd0);

      // Cache busy for 5 cycles while requesting.
      cycle(1'b0, 1'b1, 1'b1, 32'h200);
      cycle(1'b1, 1'b1, 1'b0, '0);
      n0 = acc_q.size();
      for (int i = 0; i < 5; i++) begin
         check("busy_re_held",   32'(cache_re), 32'd1);
         check("busy_addr_held", cache_addr, 32'h200);
         cycle(1'b1, 1'b1, 1'b0, '0);
      end
      check("busy_no_accept", 32'(acc_q.size() - n0), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, '0);
      check("busy_one_accept", 32'(acc_q.size() - n0), 32'd1);
      if (acc_q.size() == n0 + 1) check("busy_accept_addr", acc_q[n0], 32'h200);

      // Redirect while waiting on the cache.
      lat_min = 3; lat_max = 3;
      cycle(1'b0, 1'b1, 1'b1, 32'h400);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (dbg_state == 2'(WAIT) && pend_wait > 0) found = 1;
         else cycle(1'b0, 1'b1, 1'b0, '0);
      end
      check("reach_wait", 32'(found), 32'd1);
      cycle(1'b0, 1'b1, 1'b1, 32'h1003);
      check("redir_out_valid", 32'(out_valid), 32'd0);
      check("redir_state_drop", 32'(dbg_state), 32'(DROP));
      n0 = acc_q.size();
      for (int i = 0; i < 20 && acc_q.size() == n0; i++) cycle(1'b0, 1'b1, 1'b0, '0);
      check("redir_refetch", 32'(acc_q.size() > n0), 32'd1);
      if (acc_q.size() > n0) check("redir_target", acc_q[n0], 32'h1000);

      // Redirect in the same cycle as a response and a pop.
      lat_min = 0; lat_max = 0;
      cycle(1'b0, 1'b0, 1'b1, 32'h1800);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (dbg_state == 2'(WAIT) && pend_valid && pend_wait == 0 && exp_q.size() >= 1) found = 1;
         else cycle(1'b0, 1'b0, 1'b0, '0);
      end
      check("reach_done_pop", 32'(found), 32'd1);
      cycle(1'b0, 1'b1, 1'b1, 32'h2000);
      check("coinc_out_valid", 32'(out_valid), 32'd0);
      check("coinc_state_idle", 32'(dbg_state), 32'(IDLE));
      n0 = acc_q.size();
      for (int i = 0; i < 10 && acc_q.size() == n0; i++) cycle(1'b0, 1'b1, 1'b0, '0);
      check("coinc_refetch", 32'(acc_q.size() > n0), 32'd1);
      if (acc_q.size() > n0) check("coinc_target", acc_q[n0], 32'h2000);

      // Randomized traffic against the model.
      lat_min = 0; lat_max = 3;
      for (int i = 0; i < 2000; i++) begin
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 15) == 0, $urandom());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
